// File: rtl/acc_row_ctrl.sv
// acc_row_ctrl: result buffer and sequencer at the bottom edge of the
// systolic array. It collects the skewed column outputs into a ROWS x COLS
// buffer, with one write pointer per column. It then drains the buffer one
// row per handshake toward the unified buffer.
//
// Optional build macro: ACC_ROW_CTRL_ACCUM_EN
//   When it is defined, a start with acc_mode=1 keeps the buffer contents.
//   COLLECT writes then add into the existing entry (modulo 2^DATA_W).
//   When it is undefined, acc_mode is ignored and writes overwrite.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; buffer holds the previous pass
// S_COLLECT | per-column writes until every column holds ROWS entries
// S_DRAIN   | presenting buffer[drain_ptr] with out_valid, one row per accept
// S_DONE    | one-cycle done pulse, then back to idle
module acc_row_ctrl #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     acc_mode,
    input  logic [COLS-1:0]          col_valid,
    input  logic [COLS*DATA_W-1:0]   col_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*DATA_W-1:0]   out_row,
    output logic [$clog2(ROWS)-1:0]  out_row_idx,
    output logic                     busy,
    output logic                     full,
    output logic                     done,
    output logic                     overflow
);

    localparam int RW = $clog2(ROWS);
    // A column pointer must be able to reach ROWS itself ("column complete").
    localparam int PW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PW-1:0]       ptr [COLS];
    logic [RW-1:0]       drain_ptr;
    logic [DATA_W-1:0]   mem [ROWS][COLS];

    logic [COLS-1:0]     wr_en;
    logic [COLS-1:0]     drop;
    logic                all_full_next;
    logic                start_go;
    logic                handshake;
    logic                last_row;
    logic                clear_buf;

`ifdef ACC_ROW_CTRL_ACCUM_EN
    assign clear_buf = !acc_mode;
`else
    logic unused_acc_mode;
    assign unused_acc_mode = acc_mode;
    assign clear_buf       = 1'b1;
`endif

    assign start_go  = (state == S_IDLE) && start;
    assign handshake = (state == S_DRAIN) && out_ready;
    assign last_row  = (drain_ptr == RW'(ROWS - 1));

    // Per-column write enables, dropped writes, and the "all columns complete after this edge" flag.
    always_comb begin
        wr_en         = '0;
        drop          = '0;
        all_full_next = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            wr_en[c] = (state == S_COLLECT) && col_valid[c] && (ptr[c] != PW'(ROWS));
            drop[c]  = col_valid[c] && !wr_en[c];
            if (!((ptr[c] == PW'(ROWS)) ||
                  (wr_en[c] && (ptr[c] == PW'(ROWS - 1))))) begin
                all_full_next = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The last collect write moves straight into DRAIN.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start)                      state_next = S_COLLECT;
            S_COLLECT: if (all_full_next)              state_next = S_DRAIN;
            S_DRAIN:   if (out_ready && last_row)      state_next = S_DONE;
            S_DONE:                                    state_next = S_IDLE;
            default:                                   state_next = S_IDLE;
        endcase
    end

    // Status outputs and the row mux. The row is gated so it reads zero outside DRAIN.
    always_comb begin
        busy        = (state != S_IDLE);
        full        = (state == S_DRAIN);
        out_valid   = (state == S_DRAIN);
        done        = (state == S_DONE);
        out_row     = '0;
        out_row_idx = '0;
        if (state == S_DRAIN) begin
            out_row_idx = drain_ptr;
            for (int r = 0; r < ROWS; r++) begin
                if (drain_ptr == RW'(r)) begin
                    for (int c = 0; c < COLS; c++) begin
                        out_row[c*DATA_W +: DATA_W] = mem[r][c];
                    end
                end
            end
        end
    end

    // Pointers, sticky overflow, and buffer storage. A start edge takes priority over stray writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            drain_ptr <= '0;
            for (int c = 0; c < COLS; c++) begin
                ptr[c] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (start_go) begin
            overflow  <= 1'b0;
            drain_ptr <= '0;
            for (int c = 0; c < COLS; c++) begin
                ptr[c] <= '0;
            end
            if (clear_buf) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mem[r][c] <= '0;
                    end
                end
            end
        end else begin
            if (|drop) begin
                overflow <= 1'b1;
            end
            for (int c = 0; c < COLS; c++) begin
                if (wr_en[c]) begin
                    ptr[c] <= ptr[c] + PW'(1);
                    for (int r = 0; r < ROWS; r++) begin
                        if (ptr[c] == PW'(r)) begin
`ifdef ACC_ROW_CTRL_ACCUM_EN
                            mem[r][c] <= mem[r][c] + col_data[c*DATA_W +: DATA_W];
`else
                            mem[r][c] <= col_data[c*DATA_W +: DATA_W];
`endif
                        end
                    end
                end
            end
            if (handshake) begin
                drain_ptr <= last_row ? '0 : drain_ptr + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_row_ctrl.sv
// tb_acc_row_ctrl: directed test of acc_row_ctrl with the default sizes
// ROWS=COLS=2 and DATA_W=8. Expected rows are computed by hand.
module tb_acc_row_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        acc_mode;
    logic [1:0]  col_valid;
    logic [15:0] col_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_row;
    logic [0:0]  out_row_idx;
    logic        busy;
    logic        full;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    acc_row_ctrl #(.ROWS(2), .COLS(2), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .acc_mode    (acc_mode),
        .col_valid   (col_valid),
        .col_data    (col_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .busy        (busy),
        .full        (full),
        .done        (done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic acc);
        start    = 1'b1;
        acc_mode = acc;
        step();
        start    = 1'b0;
        acc_mode = 1'b0;
    endtask

    // Skewed fill: col0 writes on cycles 1 and 2, col1 writes on cycles 2 and 3.
    task automatic load(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1);
        col_valid = 2'b01; col_data = {8'h00, a0}; step();
        col_valid = 2'b11; col_data = {b0, a1};    step();
        col_valid = 2'b10; col_data = {b1, 8'h00}; step();
        col_valid = 2'b00; col_data = 16'h0;
    endtask

    // Must be entered in DRAIN with out_ready=1.
    task automatic drain_check(input string tag, input logic [15:0] r0, input logic [15:0] r1);
        chk({tag, " valid0"}, out_valid, 1'b1);
        chk({tag, " full0"},  full,      1'b1);
        chk({tag, " row0"},   out_row,   r0);
        chk({tag, " idx0"},   out_row_idx, 1'b0);
        step();
        chk({tag, " row1"},   out_row,   r1);
        chk({tag, " idx1"},   out_row_idx, 1'b1);
        step();
        chk({tag, " done"},   done,      1'b1);
        chk({tag, " dvalid"}, out_valid, 1'b0);
        chk({tag, " dbusy"},  busy,      1'b1);
        step();
        chk({tag, " idle_done"}, done, 1'b0);
        chk({tag, " idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        acc_mode  = 1'b0;
        col_valid = 2'b00;
        col_data  = 16'h0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst valid", out_valid, 1'b0);
        chk("rst row",   out_row,   16'h0);
        chk("rst idx",   out_row_idx, 1'b0);
        chk("rst busy",  busy,      1'b0);
        chk("rst full",  full,      1'b0);
        chk("rst done",  done,      1'b0);
        chk("rst ovf",   overflow,  1'b0);
        reset = 1'b0;
        step();

        // 1: skewed fill with out_ready held high
        do_start(1'b0);
        chk("t1 busy", busy, 1'b1);
        chk("t1 valid_early", out_valid, 1'b0);
        col_valid = 2'b01; col_data = 16'h0005; step();
        col_valid = 2'b11; col_data = 16'h0607; step();
        chk("t1 valid_pre", out_valid, 1'b0);
        col_valid = 2'b10; col_data = 16'h0800; step();
        col_valid = 2'b00; col_data = 16'h0;
        drain_check("t1", 16'h0605, 16'h0807);
        chk("t1 ovf", overflow, 1'b0);

        // 2: backpressure for three cycles
        out_ready = 1'b0;
        do_start(1'b0);
        load(8'h05, 8'h07, 8'h06, 8'h08);
        for (int i = 0; i < 3; i++) begin
            chk("t2 hold_valid", out_valid, 1'b1);
            chk("t2 hold_row",   out_row,   16'h0605);
            chk("t2 hold_idx",   out_row_idx, 1'b0);
            step();
        end
        out_ready = 1'b1;
        drain_check("t2", 16'h0605, 16'h0807);

        // 3: third col0 write while col1 is still filling
        do_start(1'b0);
        col_valid = 2'b01; col_data = 16'h0005; step();
        col_valid = 2'b11; col_data = 16'h0607; step();
        chk("t3 ovf_pre", overflow, 1'b0);
        col_valid = 2'b11; col_data = 16'h0899; step();
        col_valid = 2'b00; col_data = 16'h0;
        chk("t3 ovf_set", overflow, 1'b1);
        drain_check("t3", 16'h0605, 16'h0807);
        chk("t3 ovf_idle", overflow, 1'b1);
        do_start(1'b0);
        chk("t3 ovf_clr", overflow, 1'b0);
        load(8'h05, 8'h07, 8'h06, 8'h08);
        drain_check("t3b", 16'h0605, 16'h0807);

        // 4: start ignored during DRAIN, stray write in IDLE
        do_start(1'b0);
        load(8'h05, 8'h07, 8'h06, 8'h08);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4 row1", out_row, 16'h0807);
        chk("t4 idx1", out_row_idx, 1'b1);
        chk("t4 ovf_drain", overflow, 1'b0);
        step();
        chk("t4 done", done, 1'b1);
        step();
        chk("t4 idle", busy, 1'b0);
        col_valid = 2'b01; col_data = 16'h0055; step();
        col_valid = 2'b00; col_data = 16'h0;
        chk("t4 ovf_stray", overflow, 1'b1);
        chk("t4 busy_stray", busy, 1'b0);

        // 5: reset after row0 is accepted
        do_start(1'b0);
        load(8'h05, 8'h07, 8'h06, 8'h08);
        step();
        chk("t5 idx1", out_row_idx, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5 valid", out_valid, 1'b0);
        chk("t5 busy",  busy,      1'b0);
        chk("t5 full",  full,      1'b0);
        chk("t5 row",   out_row,   16'h0);
        chk("t5 ovf",   overflow,  1'b0);
        step();
        chk("t5 hold_valid", out_valid, 1'b0);
        reset = 1'b0;
        step();
        chk("t5 idle_done", done, 1'b0);
        do_start(1'b0);
        load(8'h11, 8'h33, 8'h22, 8'h44);
        drain_check("t5", 16'h2211, 16'h4433);

        // 6: accumulate pass on top of a normal pass
        do_start(1'b0);
        load(8'd5, 8'd1, 8'd200, 8'd2);
        drain_check("t6a", 16'hC805, 16'h0201);
        do_start(1'b1);
        load(8'd3, 8'd10, 8'd100, 8'd20);
`ifdef ACC_ROW_CTRL_ACCUM_EN
        drain_check("t6b", 16'h2C08, 16'h160B);
`else
        drain_check("t6b", 16'h6403, 16'h140A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
